// File: rtl/mem_burst_initiator_pkg.sv
// Shared types and constants for the mem_burst_initiator slice.
// Optional build macro: MEM_SCRUB_EN adds the post-reset SCRUB state.
package mem_burst_initiator_pkg;

  localparam int unsigned RAM_BYTES = 16;
  localparam int unsigned ADDR_BITS = 4;
  localparam int unsigned DATA_BITS = 8;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  localparam logic [DATA_BITS-1:0] SCRUB_DATA = DATA_BITS'(8'h00);

  // FSM encoding kept as plain constants for compatibility with older tooling
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WRITE    = 3'd1;
  localparam state_t ST_RD_ISSUE = 3'd2;
  localparam state_t ST_RD_WAIT  = 3'd3;
  localparam state_t ST_RD_HOLD  = 3'd4;
`ifdef MEM_SCRUB_EN
  localparam state_t ST_SCRUB    = 3'd5;
`endif

  // Registered RAM-side request
  typedef struct packed {
    logic                 wr_en;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
  } mem_req_t;

  // Next RAM address, wrapping at the end of the array
  function automatic logic [ADDR_BITS-1:0] addr_wrap_inc(input logic [ADDR_BITS-1:0] a);
    return ADDR_BITS'((32'(a) + 32'd1) % RAM_BYTES);
  endfunction

endpackage

// File: rtl/mem_addr_seq.sv
// Wrapping address pointer plus remaining-byte down-counter for one burst.
module mem_addr_seq
  import mem_burst_initiator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [ADDR_BITS-1:0] load_len,
  input  logic                 step,
  output logic [ADDR_BITS-1:0] ptr,
  output logic                 last_c
);

  logic [ADDR_BITS-1:0] cnt_q;
  logic [ADDR_BITS-1:0] cnt_nxt;
  logic [ADDR_BITS-1:0] ptr_nxt;

  // Load wins over step; the count saturates at zero
  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt_q;
    if (load) begin
      ptr_nxt = load_addr;
      cnt_nxt = load_len;
    end else if (step) begin
      ptr_nxt = addr_wrap_inc(ptr);
      if (cnt_q != '0) begin
        cnt_nxt = cnt_q - ADDR_BITS'(1);
      end
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      cnt_q <= '0;
    end else begin
      ptr   <= ptr_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign last_c = (cnt_q == '0);

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst initiator between host glue and the 16-byte DFF RAM port.
// Optional build macro: MEM_SCRUB_EN zero-fills the RAM after every reset.
module mem_burst_initiator
  import mem_burst_initiator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_op,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [ADDR_BITS-1:0] cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  localparam mem_req_t MEM_REQ_IDLE = '{wr_en: 1'b0, rd_en: 1'b0, addr: '0, wdata: SCRUB_DATA};

  state_t               state_q;
  state_t               state_nxt;
  mem_req_t             mem_q;
  mem_req_t             mem_nxt;
  logic                 ready_q;
  logic                 ready_nxt;
  logic                 wr_ready_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 rd_valid_nxt;
  logic [DATA_BITS-1:0] rd_data_nxt;

  logic                 seq_load;
  logic [ADDR_BITS-1:0] seq_load_addr;
  logic [ADDR_BITS-1:0] seq_load_len;
  logic                 seq_step;
  logic [ADDR_BITS-1:0] ptr;
  logic                 last_c;

  logic                 cmd_fire_c;
  logic                 wr_fire_c;
  logic                 rd_fire_c;

`ifdef MEM_SCRUB_EN
  logic                 scrub_req_q;
  logic                 scrub_req_nxt;
`endif

  // ready_q tracks "registered state is IDLE"; ena gates new commands only
  assign cmd_ready  = ready_q & ena;
  assign cmd_fire_c = cmd_valid & cmd_ready;
  assign wr_fire_c  = wr_valid & wr_ready;
  assign rd_fire_c  = rd_valid & rd_ready;

  assign mem_addr   = mem_q.addr;
  assign mem_wr_en  = mem_q.wr_en;
  assign mem_rd_en  = mem_q.rd_en;
  assign mem_wdata  = mem_q.wdata;

  mem_addr_seq u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (seq_load),
    .load_addr (seq_load_addr),
    .load_len  (seq_load_len),
    .step      (seq_step),
    .ptr       (ptr),
    .last_c    (last_c)
  );

  // Next-state and next-output decode
  always_comb begin
    state_nxt     = state_q;
    mem_nxt       = mem_q;
    mem_nxt.wr_en = 1'b0;
    mem_nxt.rd_en = 1'b0;
    done_nxt      = 1'b0;
    rd_valid_nxt  = rd_valid;
    rd_data_nxt   = rd_data;
    seq_load      = 1'b0;
    seq_load_addr = cmd_addr;
    seq_load_len  = cmd_len;
    seq_step      = 1'b0;
`ifdef MEM_SCRUB_EN
    scrub_req_nxt = scrub_req_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef MEM_SCRUB_EN
        if (scrub_req_q) begin
          scrub_req_nxt = 1'b0;
          seq_load      = 1'b1;
          seq_load_addr = '0;
          seq_load_len  = ADDR_BITS'(RAM_BYTES - 1);
          state_nxt     = ST_SCRUB;
        end else
`endif
        if (cmd_fire_c) begin
          seq_load = 1'b1;
          case (cmd_op)
            OP_WRITE: state_nxt = ST_WRITE;
            OP_READ: begin
              // Strobe goes out while in RD_ISSUE so data lands during RD_WAIT
              state_nxt     = ST_RD_ISSUE;
              mem_nxt.rd_en = 1'b1;
              mem_nxt.addr  = cmd_addr;
            end
            default: state_nxt = ST_IDLE;
          endcase
        end
      end

      ST_WRITE: begin
        if (wr_fire_c) begin
          mem_nxt.wr_en = 1'b1;
          mem_nxt.addr  = ptr;
          mem_nxt.wdata = wr_data;
          seq_step      = 1'b1;
          if (last_c) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_RD_ISSUE: begin
        state_nxt = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        rd_data_nxt  = mem_rdata;
        rd_valid_nxt = 1'b1;
        state_nxt    = ST_RD_HOLD;
      end

      ST_RD_HOLD: begin
        if (rd_fire_c) begin
          rd_valid_nxt = 1'b0;
          if (last_c) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            seq_step      = 1'b1;
            mem_nxt.rd_en = 1'b1;
            mem_nxt.addr  = addr_wrap_inc(ptr);
            state_nxt     = ST_RD_ISSUE;
          end
        end
      end

`ifdef MEM_SCRUB_EN
      ST_SCRUB: begin
        mem_nxt.wr_en = 1'b1;
        mem_nxt.addr  = ptr;
        mem_nxt.wdata = SCRUB_DATA;
        seq_step      = 1'b1;
        if (last_c) begin
          state_nxt = ST_IDLE;
        end
      end
`endif

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    ready_nxt    = (state_nxt == ST_IDLE);
    wr_ready_nxt = (state_nxt == ST_WRITE);
    busy_nxt     = (state_nxt != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_q       <= MEM_REQ_IDLE;
      ready_q     <= 1'b0;
      wr_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
`ifdef MEM_SCRUB_EN
      scrub_req_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_nxt;
      mem_q       <= mem_nxt;
      ready_q     <= ready_nxt;
      wr_ready    <= wr_ready_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      rd_valid    <= rd_valid_nxt;
      rd_data     <= rd_data_nxt;
`ifdef MEM_SCRUB_EN
      scrub_req_q <= scrub_req_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Scoreboard bench for mem_burst_initiator with a behavioural RAM model.
module tb_mem_burst_initiator;
  import mem_burst_initiator_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [3:0] mem_addr;
  logic       mem_wr_en;
  logic       mem_rd_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;

  mem_burst_initiator dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data valid the cycle after the rd_en cycle
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  int          exp_done = 0;
  logic [7:0]  wq[$];
  logic [7:0]  rq[$];

  int wr_seen = 0, rd_en_seen = 0, done_seen = 0;
  int first_wr = -1, last_wr = -1, last_acc = -1;
  bit gap_en = 1'b0;
  logic [11:0] mon_e;
  logic [7:0]  mon_r;

  // Monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wr_en) begin
        wr_seen++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL mem_write unexpected addr=%0h data=%0h", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_wr.pop_front();
          if ({mem_addr, mem_wdata} !== mon_e) begin
            errors++;
            $display("FAIL mem_write got addr=%0h data=%0h want addr=%0h data=%0h",
                     mem_addr, mem_wdata, mon_e[11:8], mon_e[7:0]);
          end
        end
      end
      if (mem_rd_en) begin
        rd_en_seen++;
        checks++;
        if (mem_wr_en) begin
          errors++;
          $display("FAIL strobe_overlap got wr_en=%0b rd_en=%0b want not both", mem_wr_en, mem_rd_en);
        end
      end
      if (rd_valid && rd_ready) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_byte unexpected got=%0h", rd_data);
        end else begin
          mon_r = exp_rd.pop_front();
          if (rd_data !== mon_r) begin
            errors++;
            $display("FAIL rd_byte got=%0h want=%0h", rd_data, mon_r);
          end
        end
        if (gap_en && last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 3) begin
            errors++;
            $display("FAIL rd_spacing got=%0d want=3", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      if (done) begin
        done_seen++;
        checks++;
        if (exp_done == 0) begin
          errors++;
          $display("FAIL done_pulse unexpected got=1 want=0");
        end else begin
          exp_done--;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({cmd_ready, wr_ready, busy, done, rd_valid, rd_data,
                mem_wr_en, mem_rd_en, mem_addr, mem_wdata});
  endfunction

  task automatic send_cmd(input logic op, input logic [3:0] a, input logic [3:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept timeout got cmd_ready=0 want 1");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] a, input logic [3:0] l, input int nbytes,
                             input bit expect_done, input bit drop_ena);
    int n;
    for (int i = 0; i < nbytes; i++) exp_wr.push_back({4'(32'(a) + i), wq[i]});
    if (expect_done) exp_done++;
    first_wr = -1;
    send_cmd(OP_WRITE, a, l);
    if (drop_ena) ena = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      wr_valid = 1'b1; wr_data = wq[i];
      n = 0;
      @(negedge clk);
      while (!wr_ready && n < 20) begin @(negedge clk); n++; end
      if (!wr_ready) begin
        checks++; errors++;
        $display("FAIL wr_handshake timeout got wr_ready=0 want 1");
      end
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_burst(input logic [3:0] a, input logic [3:0] l);
    for (int i = 0; i < int'(l) + 1; i++) exp_rd.push_back(rq[i]);
    exp_done++;
    last_acc = -1;
    send_cmd(OP_READ, a, l);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_done != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout got wr=%0d rd=%0d done=%0d want 0", name,
               exp_wr.size(), exp_rd.size(), exp_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    int n = 0;
    int wr0;
`ifdef MEM_SCRUB_EN
    for (int i = 0; i < 16; i++) exp_wr.push_back({4'(i), 8'h00});
    first_wr = -1;
`endif
    wr0 = wr_seen;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
`ifdef MEM_SCRUB_EN
    chk("scrub_busy", 32'(busy), 32'd1);
    while (!cmd_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk("scrub_ready_cycles", 32'(n), 32'd16);
    @(negedge clk);
    chk("scrub_writes", 32'(wr_seen - wr0), 32'd16);
    chk("scrub_consecutive", 32'(last_wr - first_wr), 32'd15);
    @(posedge clk); #1;
`else
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    chk("idle_after_reset", 32'(busy), 32'd0);
    chk("no_write_after_reset", 32'(wr_seen - wr0), 32'd0);
`endif
  endtask

  initial begin
    int rden0, done0;
    ena = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    release_reset();

    // ena low blocks commands
    ena = 1'b0;
    @(negedge clk);
    chk("ena_low_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_op = OP_WRITE;
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("ena_low_ignored", 32'(busy), 32'd0);
    ena = 1'b1;

    // Back-to-back write A1..D4 at 3..6
    wq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    done0 = done_seen;
    write_burst(4'd3, 4'd3, 4, 1'b1, 1'b0);
    wait_drain("write_3", 40);
    chk("write_consecutive", 32'(last_wr - first_wr), 32'd3);
    chk("write_done_once", 32'(done_seen - done0), 32'd1);
    chk("write_busy_low", 32'(busy), 32'd0);

    // Read back 3..6 with rd_ready high, 3-cycle spacing
    rq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rd_ready = 1'b1; gap_en = 1'b1;
    read_burst(4'd3, 4'd3);
    wait_drain("read_3", 60);
    chk("read_busy_low", 32'(busy), 32'd0);

    // Wrap write 14,15,0,1 with ena dropped mid-burst
    wq = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    write_burst(4'd14, 4'd3, 4, 1'b1, 1'b1);
    wait_drain("write_wrap", 40);
    ena = 1'b1;
    rq = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    read_burst(4'd14, 4'd3);
    wait_drain("read_wrap", 60);

    // Backpressure on a 2-byte read, with a command offered while busy
    gap_en = 1'b0; rd_ready = 1'b0;
    rq = '{8'hA1, 8'hB2};
    read_burst(4'd3, 4'd1);
    begin
      int n = 0;
      @(negedge clk);
      while (!rd_valid && n < 20) begin @(negedge clk); n++; end
    end
    rden0 = rd_en_seen;
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 4'd0; cmd_len = 4'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_rd_valid", 32'(rd_valid), 32'd1);
      chk("hold_rd_data", 32'(rd_data), 32'hA1);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    chk("hold_no_reissue", 32'(rd_en_seen - rden0), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; rd_ready = 1'b1;
    wait_drain("read_backpressure", 60);

    // Reset after 2 of 4 bytes
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_burst(4'd8, 4'd3, 2, 1'b0, 1'b0);
    wait_drain("write_partial", 20);
    chk("partial_busy", 32'(busy), 32'd1);
    done0 = done_seen;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", outs(), 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    chk("midreset_no_done", 32'(done_seen - done0), 32'd0);
`ifdef MEM_SCRUB_EN
    rq = '{8'h00, 8'h00};
`else
    rq = '{8'h11, 8'h22};
`endif
    read_burst(4'd8, 4'd1);
    wait_drain("read_after_reset", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_burst_initiator.md
Name: mem_burst_initiator

Overview:
Initiator for the 16-byte DFF RAM port (addr/wr_en/r_en/8-bit data). It accepts one burst command at a time from a host over a valid/ready interface. It then streams write bytes into the RAM, or streams read bytes out of the RAM, sequencing addresses with wrap-around. It sits between host-side glue (SPI/UART decoder) and the RAM macro.

Parameters:
RAM_BYTES, 16, number of RAM locations; power of two.
ADDR_BITS, 4, address width, equals log2(RAM_BYTES).
DATA_BITS, 8, RAM word width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; when low, no new command is accepted
cmd_valid  in  1  host command valid
cmd_ready  out  1  high in IDLE only, and only when ena=1
cmd_op  in  1  0=write burst, 1=read burst
cmd_addr  in  ADDR_BITS  start address
cmd_len  in  ADDR_BITS  burst length minus 1 (0 means 1 byte, 15 means 16 bytes)
wr_valid  in  1  host write byte valid
wr_ready  out  1  high in WRITE state
wr_data  in  DATA_BITS  host write byte
rd_valid  out  1  read byte available
rd_ready  in  1  host accepts read byte
rd_data  out  DATA_BITS  read byte
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse when a burst completes
mem_addr  out  ADDR_BITS  RAM address, registered
mem_wr_en  out  1  RAM write strobe, registered
mem_rd_en  out  1  RAM read strobe, registered
mem_wdata  out  DATA_BITS  RAM write data, registered
mem_rdata  in  DATA_BITS  RAM read data, valid 1 cycle after the mem_rd_en cycle

Behaviour:
- Reset: asynchronous assertion forces all outputs and state to 0/IDLE, including rd_valid=0, mem_* = 0, done=0, and the remaining count cleared.
- Reset mid-burst aborts the burst; no done pulse follows.
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD, plus SCRUB when the optional feature is built.
- IDLE: on cmd_valid && cmd_ready, latch the address into the pointer and cmd_len into the remaining count, then go to WRITE (op=0) or RD_ISSUE (op=1).
- WRITE, per handshake (wr_valid && wr_ready):
  - Next cycle: mem_wr_en=1, mem_addr=ptr, mem_wdata=wr_data.
  - ptr increments modulo RAM_BYTES (15 wraps to 0).
  - If the remaining count was 0: pulse done, return to IDLE.
  - Otherwise decrement the count.
  - Back-to-back writes at 1 byte/cycle are allowed. mem_wr_en is low on cycles with no handshake.
- RD_ISSUE: drive mem_rd_en=1 with mem_addr=ptr for one cycle, then go to RD_WAIT.
- RD_WAIT: capture mem_rdata into rd_data, set rd_valid=1, go to RD_HOLD.
- RD_HOLD: hold rd_data stable while rd_valid && !rd_ready. On acceptance:
  - If the remaining count is 0: pulse done (same cycle the accepted byte drops), go to IDLE.
  - Otherwise decrement the count, increment ptr (wrapping), go to RD_ISSUE.
- Read throughput with rd_ready held high: 1 byte per 3 cycles. Only one read is in flight at any time.
- mem_wr_en and mem_rd_en are never high in the same cycle.
- A command asserted while busy is ignored; cmd_ready stays 0.
- ena dropping mid-burst does not stall the burst; it only blocks the next command.
- Length wraps: cmd_len=15 starting at addr 9 touches addresses 9..15, then 0..8.

Optional Feature:
- MEM_SCRUB_EN defined: after reset release, enter SCRUB.
  - Write 0x00 to addresses 0..RAM_BYTES-1, one per cycle; mem_wr_en is high for RAM_BYTES consecutive cycles.
  - busy=1 and cmd_ready=0 throughout SCRUB.
  - Then go to IDLE with no done pulse.
- MEM_SCRUB_EN undefined: the reset exit goes directly to IDLE. There is no SCRUB state.

Decomposition:
- Shared package: the state enum, the op encoding constants (OP_WRITE=0, OP_READ=1), RAM_BYTES/ADDR_BITS/DATA_BITS defaults, and SCRUB_DATA=8'h00.
- One natural sub-module: mem_addr_seq, the wrapping pointer plus remaining-count down-counter, with load/step/last outputs.
- The FSM and registered memory drivers stay in the top level.

Test Plan:
- Write cmd addr=3 len=3, bytes A1,B2,C3,D4 back-to-back -> mem_wr_en high 4 consecutive cycles at addrs 3,4,5,6 with the matching data; done pulses once; busy falls.
- Read cmd addr=3 len=3 with rd_ready=1, against a RAM model -> rd_data A1,B2,C3,D4 in order; 3 cycles apart; mem_rd_en never coincides with mem_wr_en.
- Wrap: write addr=14 len=3 -> addresses 14,15,0,1. Read back the same range -> identical data.
- Backpressure: read len=1 with rd_ready=0 for 5 cycles -> rd_data stable and rd_valid held. No second mem_rd_en is issued until acceptance.
- Reset mid-write after 2 of 4 bytes -> all outputs 0, state IDLE, no done. A new command is accepted after release with ena=1.
- Built with MEM_SCRUB_EN: after reset -> 16 writes of 0x00 to addrs 0..15; cmd_ready=0 throughout, then 1. Without the macro: cmd_ready=1 on the first cycle after reset with ena=1.
